sha256_job_sequencer: RTL and testbench
=======================================

Name: sha256_job_sequencer

Overview:
- Sequences the SHA256 core for one multi-block hash job.
- Buffers each 512-bit block from an upstream valid/ready word stream, then issues soc and drives 16 contiguous words onto the core's shared data bus.
- Waits for eoc, repeats for every block, then asserts rd and returns the 8 digest words as a stream.
- Sits between the KDF feedback-mode controller and the SHA256 core. The top level ties sha_dout/sha_oe/sha_din to the core's inout data bus.

Parameters:
- BLK_W, 8: width of the block-count field; jobs carry up to 2^BLK_W-1 blocks.
- TIMEOUT, 255: maximum COMPUTE cycles to wait for eoc before flagging an error.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle job request; ignored unless busy=0.
- num_blocks  in  BLK_W  block count, latched on an accepted start.
- msg_valid  in  1  upstream message word valid.
- msg_data  in  32  message word, already padded, MSW first.
- msg_ready  out  1  high only in FILL; a word transfers when valid&&ready.
- sha_rst  out  1  core reset pulse.
- sha_soc  out  1  core start-of-computation.
- sha_rd  out  1  core digest read enable.
- sha_eoc  in  1  core end-of-computation.
- sha_dout  out  32  word driven toward the core bus.
- sha_oe  out  1  bus drive enable; 0 releases the bus (z).
- sha_din  in  32  core bus read-back.
- hash_valid  out  1  digest word valid, one cycle per word.
- hash_idx  out  3  digest word index 0..7 (H0 first).
- hash_word  out  32  digest word.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle job-complete pulse.
- error  out  1  eoc timeout flag; held until the next accepted start.

Behaviour:
- Reset (async): state=IDLE, all outputs 0, sha_oe=0, counters and buffer pointers cleared. Reset mid-job abandons the job with no done pulse.
- IDLE:
  - start with num_blocks=0: done pulses on the next cycle, error=0, no core activity.
  - start with num_blocks>0: latch count, clear error, busy=1, go to CRST.
- CRST: sha_rst=1 for exactly 1 cycle, then FILL.
- FILL:
  - msg_ready=1; each transfer writes buf[wr_ptr] and increments wr_ptr.
  - Stalls (msg_valid=0) allowed indefinitely.
  - After the 16th transfer: msg_ready=0, go to SOC.
- SOC: sha_soc=1 for exactly 1 cycle, then LOAD.
- LOAD:
  - 16 consecutive cycles, no bubbles; sha_oe=1, sha_dout=buf[k] in the k-th cycle (k=0..15).
  - The first word appears the cycle after sha_soc.
- COMPUTE:
  - sha_oe=0; the cycle counter starts at 0.
  - sha_eoc sampled 1: decrement the remaining block count. If blocks remain, go to FILL (wr_ptr=0); else go to READ.
  - Counter reaches TIMEOUT with no eoc: error=1, done=1, busy=0, go to IDLE; no digest output.
- READ:
  - sha_rd=1 for 8 consecutive cycles. sha_din is sampled at the end of the j-th rd cycle.
  - The next cycle presents hash_valid=1, hash_idx=j, hash_word=sample. The digest stream lags sha_rd by 1 cycle and is 8 contiguous beats.
  - done pulses with the idx=7 beat; busy drops on the following cycle.
- Simultaneous events:
  - start while busy: ignored.
  - eoc during LOAD/FILL: ignored.
  - msg_valid outside FILL: no transfer.
- A block's 16 words are never partially loaded to the core; buffering completes before soc.
- Total job latency for N blocks with no stalls: 1 + N·(16+1+16+Tc) + 8 + 1 cycles, where Tc is the core compute time.

Test Plan:
- "abc" job: num_blocks=1, words 0x61626380, fourteen 0x00000000, 0x00000018; real core → hash_idx 0..7 = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, one done pulse, error=0.
- Two-block "abcdbcde…nopq" (448-bit) message with msg_valid toggled 1-0-1 randomly → digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. Also check that sha_soc and sha_rst each pulsed exactly 2 and 1 cycles respectively, and that the LOAD phases have no gaps.
- Stub core that never asserts eoc, TIMEOUT=255 → error=1 and done pulse exactly 256 cycles after the last LOAD cycle, no hash_valid, sha_oe=0 throughout COMPUTE.
- num_blocks=0 → done on the next cycle, sha_soc/sha_rst/sha_rd never asserted.
- rst asserted during LOAD word 7 → all outputs 0 within the same cycle (async), sha_oe=0. A subsequent "abc" job then produces the correct digest.
- start re-pulsed during COMPUTE and READ → ignored; digest and single done unchanged.

Source files
------------

// File: rtl/sha256_job_sequencer.sv
// Sequences a SHA256 core through one multi-block job: buffer a block, pulse soc, load 16 words,
// wait for eoc, repeat per block, then read back and stream the 8 digest words.
module sha256_job_sequencer #(
  parameter int BLK_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BLK_W-1:0] num_blocks,
  input  logic             msg_valid,
  input  logic [31:0]      msg_data,
  output logic             msg_ready,
  output logic             sha_rst,
  output logic             sha_soc,
  output logic             sha_rd,
  input  logic             sha_eoc,
  output logic [31:0]      sha_dout,
  output logic             sha_oe,
  input  logic [31:0]      sha_din,
  output logic             hash_valid,
  output logic [2:0]       hash_idx,
  output logic [31:0]      hash_word,
  output logic             busy,
  output logic             done,
  output logic             error
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, CRST, FILL, SOC, LOAD, COMPUTE, READ, LAST} state_t;

  state_t           state;
  logic [31:0]      blk_buf [16];
  logic [3:0]       wr_ptr;
  logic [3:0]       rd_ptr;
  logic [2:0]       beat;
  logic [BLK_W-1:0] blocks_left;
  logic [CNT_W-1:0] cnt;
  logic             xfer;

  assign xfer = msg_valid && msg_ready;

  // Block buffer needs no reset: it is only read after a complete FILL.
  always_ff @(posedge clk)
    if (xfer) blk_buf[wr_ptr] <= msg_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      msg_ready   <= 1'b0;
      sha_rst     <= 1'b0;
      sha_soc     <= 1'b0;
      sha_rd      <= 1'b0;
      sha_dout    <= '0;
      sha_oe      <= 1'b0;
      hash_valid  <= 1'b0;
      hash_idx    <= '0;
      hash_word   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      beat        <= '0;
      blocks_left <= '0;
      cnt         <= '0;
    end else begin
      sha_rst    <= 1'b0;
      sha_soc    <= 1'b0;
      hash_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: if (start) begin
          error <= 1'b0;
          if (num_blocks == '0) begin
            done <= 1'b1;
          end else begin
            blocks_left <= num_blocks;
            busy        <= 1'b1;
            sha_rst     <= 1'b1;
            state       <= CRST;
          end
        end
        CRST: begin
          msg_ready <= 1'b1;
          wr_ptr    <= '0;
          state     <= FILL;
        end
        FILL: if (xfer) begin
          wr_ptr <= wr_ptr + 4'd1;
          if (wr_ptr == 4'd15) begin
            msg_ready <= 1'b0;
            sha_soc   <= 1'b1;
            state     <= SOC;
          end
        end
        SOC: begin
          sha_oe   <= 1'b1;
          sha_dout <= blk_buf[0];
          rd_ptr   <= 4'd1;
          state    <= LOAD;
        end
        // rd_ptr wraps to 0 while the 16th word is on the bus.
        LOAD: if (rd_ptr == 4'd0) begin
          sha_oe   <= 1'b0;
          sha_dout <= '0;
          cnt      <= '0;
          state    <= COMPUTE;
        end else begin
          sha_dout <= blk_buf[rd_ptr];
          rd_ptr   <= rd_ptr + 4'd1;
        end
        COMPUTE: if (sha_eoc) begin
          blocks_left <= blocks_left - BLK_W'(1);
          if (blocks_left == BLK_W'(1)) begin
            sha_rd <= 1'b1;
            beat   <= '0;
            state  <= READ;
          end else begin
            msg_ready <= 1'b1;
            wr_ptr    <= '0;
            state     <= FILL;
          end
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          error <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        READ: begin
          hash_valid <= 1'b1;
          hash_idx   <= beat;
          hash_word  <= sha_din;
          beat       <= beat + 3'd1;
          if (beat == 3'd7) begin
            sha_rd <= 1'b0;
            done   <= 1'b1;
            state  <= LAST;
          end
        end
        LAST: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_job_sequencer.sv
// Bench for sha256_job_sequencer: behavioural SHA256 core stub plus a job-level reference digest model.
module tb_sha256_job_sequencer;
  localparam int BLK_W   = 8;
  localparam int TIMEOUT = 255;

  localparam logic [255:0] IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [BLK_W-1:0] num_blocks = '0;
  logic msg_valid = 1'b0;
  logic [31:0] msg_data = '0;
  logic msg_ready, sha_rst, sha_soc, sha_rd, sha_oe, hash_valid, busy, done, error;
  logic sha_eoc = 1'b0;
  logic [31:0] sha_dout, sha_din, hash_word;
  logic [2:0] hash_idx;

  sha256_job_sequencer #(.BLK_W(BLK_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks),
    .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready),
    .sha_rst(sha_rst), .sha_soc(sha_soc), .sha_rd(sha_rd), .sha_eoc(sha_eoc),
    .sha_dout(sha_dout), .sha_oe(sha_oe), .sha_din(sha_din),
    .hash_valid(hash_valid), .hash_idx(hash_idx), .hash_word(hash_word),
    .busy(busy), .done(done), .error(error));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_comp(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Job message words, 16 per block, MSW first.
  logic [31:0] jw [0:127];

  function automatic logic [255:0] model_digest(input int nb);
    logic [255:0] h;
    logic [511:0] b;
    h = IV;
    for (int k = 0; k < nb; k++) begin
      for (int i = 0; i < 16; i++) b[511-32*i -: 32] = jw[16*k+i];
      h = sha_comp(h, b);
    end
    return h;
  endfunction

  // Behavioural core: captures 16 bus words after soc, hashes, raises eoc after core_tc cycles.
  int core_tc = 4;
  bit core_glitch = 1'b0;
  bit core_no_eoc = 1'b0;
  logic [255:0] core_h;
  logic [511:0] core_blk;
  int core_ld = 0;
  int core_cd = 0;
  bit core_loading = 1'b0;
  bit core_busy = 1'b0;
  logic [2:0] rd_idx = '0;

  always @(posedge clk) begin
    sha_eoc <= 1'b0;
    if (sha_eoc) core_busy = 1'b0;
    if (core_cd > 0) begin
      core_cd--;
      if (core_cd == 0) sha_eoc <= 1'b1;
    end
    if (sha_rst) begin
      core_h = IV; core_busy = 1'b0; core_cd = 0; core_loading = 1'b0;
    end
    if (sha_soc) begin
      core_loading = 1'b1; core_ld = 0;
    end else if (core_loading && sha_oe) begin
      core_blk[511-32*core_ld -: 32] = sha_dout;
      core_ld++;
      if (core_ld == 16) begin
        core_loading = 1'b0;
        core_h = sha_comp(core_h, core_blk);
        core_busy = 1'b1;
        if (!core_no_eoc) begin
          if (core_tc <= 1) sha_eoc <= 1'b1;
          else core_cd = core_tc - 1;
        end
      end
    end
    if (sha_rst || sha_soc) rd_idx <= '0;
    else if (sha_rd) rd_idx <= rd_idx + 3'd1;
    if (core_glitch && !core_busy) sha_eoc <= ($urandom_range(0, 3) == 0);
  end

  assign sha_din = core_h[255-32*rd_idx -: 32];

  // Observations of the most recent job.
  int ptr, nwords, done_cnt, done_cyc, last_load_cyc, start_cyc, hv_cnt;
  int soc_cnt, rst_cnt, rd_cnt, oe_bad, lag_bad, idx_bad, extra_xfer, oe_total, oe_run;
  bit busy_at_done, busy_after, err_end, aborted;
  logic [255:0] got_dig;

  task automatic run_job(input int nb, input int stall_pct, input int tc, input bit glitch,
                         input bit no_eoc, input bit restart, input int abort_oe);
    bit prev_soc, prev_rd, prev_oe, rs1, rs2, seen;
    int after;
    core_tc = tc; core_glitch = glitch; core_no_eoc = no_eoc;
    nwords = 16 * nb; ptr = 0; done_cnt = 0; done_cyc = -1; last_load_cyc = -1; hv_cnt = 0;
    soc_cnt = 0; rst_cnt = 0; rd_cnt = 0; oe_bad = 0; lag_bad = 0; idx_bad = 0; extra_xfer = 0;
    oe_total = 0; oe_run = 0; busy_at_done = 1'b0; busy_after = 1'b1; err_end = 1'b0;
    aborted = 1'b0; got_dig = '0;
    prev_soc = 1'b0; prev_rd = 1'b0; prev_oe = 1'b0; rs1 = 1'b0; rs2 = 1'b0; seen = 1'b0; after = 0;
    @(negedge clk);
    start = 1'b1; num_blocks = BLK_W'(nb); start_cyc = cyc;
    for (int t = 0; t < 4000; t++) begin
      if (t > 0) begin
        start = 1'b0;
        if (restart && !rs1 && prev_oe && !sha_oe) begin
          start = 1'b1; num_blocks = BLK_W'($urandom_range(0, 3)); rs1 = 1'b1;
        end
        if (restart && !rs2 && sha_rd) begin
          start = 1'b1; num_blocks = '0; rs2 = 1'b1;
        end
      end
      msg_valid = ($urandom_range(0, 99) >= stall_pct);
      msg_data = (ptr < nwords) ? jw[ptr] : $urandom;
      if (msg_valid && msg_ready) begin
        if (ptr < nwords) ptr++;
        else extra_xfer++;
      end
      if (hash_valid) begin
        if (hash_idx !== 3'(hv_cnt)) idx_bad++;
        if (hv_cnt < 8) got_dig[255-32*hv_cnt -: 32] = hash_word;
        hv_cnt++;
      end
      if (hash_valid !== prev_rd) lag_bad++;
      if (sha_soc) soc_cnt++;
      if (sha_rst) rst_cnt++;
      if (sha_rd) rd_cnt++;
      if (sha_oe) begin
        oe_run++; oe_total++; last_load_cyc = cyc;
      end else if (oe_run != 0) begin
        if (oe_run != 16) oe_bad++;
        oe_run = 0;
      end
      if (prev_soc && !sha_oe) oe_bad++;
      if (abort_oe > 0 && oe_total == abort_oe) begin
        aborted = 1'b1;
        break;
      end
      if (done) begin
        done_cnt++;
        if (!seen) begin done_cyc = cyc; busy_at_done = busy; end
        seen = 1'b1;
      end
      if (seen) begin
        if (after == 1) busy_after = busy;
        after++;
        if (after > 3) begin err_end = error; break; end
      end
      prev_soc = sha_soc; prev_rd = sha_rd; prev_oe = sha_oe;
      @(negedge clk);
    end
    start = 1'b0;
    msg_valid = 1'b0;
  endtask

  task automatic load_abc();
    jw[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) jw[i] = 32'h0;
    jw[15] = 32'h00000018;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({msg_ready, sha_rst, sha_soc, sha_rd, sha_oe, hash_valid, busy, done, error} !== 9'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0", {msg_ready, sha_rst, sha_soc, sha_rd, sha_oe, hash_valid, busy, done, error});
    end
    checks++; if ({sha_dout, hash_word, hash_idx} !== 67'b0) begin
      failures++; $display("FAIL reset_data dout=%h word=%h idx=%0d exp=0", sha_dout, hash_word, hash_idx);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abc();
    load_abc();
    run_job(1, 0, 5, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      checks++; if (got_dig[255-32*i -: 32] !== ABC[255-32*i -: 32]) begin
        failures++; $display("FAIL abc_word%0d got=%h exp=%h", i, got_dig[255-32*i -: 32], ABC[255-32*i -: 32]);
      end
    end
    checks++; if (done_cnt !== 1 || err_end !== 1'b0) begin
      failures++; $display("FAIL abc_done done_cnt=%0d error=%0b exp 1,0", done_cnt, err_end);
    end
    checks++; if (done_cyc - start_cyc !== 1 + (33 + 5) + 8 + 1) begin
      failures++; $display("FAIL abc_latency got=%0d exp=%0d", done_cyc - start_cyc, 1 + (33 + 5) + 8 + 1);
    end
    checks++; if (hv_cnt !== 8 || idx_bad !== 0 || lag_bad !== 0) begin
      failures++; $display("FAIL abc_stream beats=%0d idx_bad=%0d lag_bad=%0d exp 8,0,0", hv_cnt, idx_bad, lag_bad);
    end
    checks++; if (busy_at_done !== 1'b1 || busy_after !== 1'b0) begin
      failures++; $display("FAIL abc_busy at_done=%0b after=%0b exp 1,0", busy_at_done, busy_after);
    end
  endtask

  task automatic test_two_block();
    logic [31:0] m [0:13];
    m = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
          32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
    for (int i = 0; i < 14; i++) jw[i] = m[i];
    jw[14] = 32'h80000000;
    for (int i = 15; i < 31; i++) jw[i] = 32'h0;
    jw[31] = 32'h000001c0;
    run_job(2, 45, 7, 1'b1, 1'b0, 1'b0, 0);
    checks++; if (got_dig !== TWO) begin
      failures++; $display("FAIL two_digest got=%h exp=%h", got_dig, TWO);
    end
    checks++; if (soc_cnt !== 2 || rst_cnt !== 1 || rd_cnt !== 8) begin
      failures++; $display("FAIL two_pulses soc=%0d rst=%0d rd=%0d exp 2,1,8", soc_cnt, rst_cnt, rd_cnt);
    end
    checks++; if (oe_bad !== 0 || oe_total !== 32) begin
      failures++; $display("FAIL two_load gaps=%0d oe_cycles=%0d exp 0,32", oe_bad, oe_total);
    end
    checks++; if (done_cnt !== 1 || extra_xfer !== 0 || ptr !== 32) begin
      failures++; $display("FAIL two_done done=%0d extra=%0d words=%0d exp 1,0,32", done_cnt, extra_xfer, ptr);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 16; i++) jw[i] = $urandom;
    run_job(1, 20, 1, 1'b0, 1'b1, 1'b0, 0);
    checks++; if (done_cnt !== 1 || err_end !== 1'b1) begin
      failures++; $display("FAIL timeout_flag done=%0d error=%0b exp 1,1", done_cnt, err_end);
    end
    checks++; if (done_cyc - last_load_cyc !== TIMEOUT + 1) begin
      failures++; $display("FAIL timeout_delay got=%0d exp=%0d", done_cyc - last_load_cyc, TIMEOUT + 1);
    end
    checks++; if (hv_cnt !== 0 || rd_cnt !== 0 || oe_bad !== 0 || busy_at_done !== 1'b0) begin
      failures++; $display("FAIL timeout_quiet beats=%0d rd=%0d oe_bad=%0d busy=%0b exp 0,0,0,0", hv_cnt, rd_cnt, oe_bad, busy_at_done);
    end
  endtask

  task automatic test_zero_blocks();
    run_job(0, 0, 1, 1'b0, 1'b0, 1'b0, 0);
    checks++; if (done_cnt !== 1 || done_cyc - start_cyc !== 1) begin
      failures++; $display("FAIL zero_done count=%0d latency=%0d exp 1,1", done_cnt, done_cyc - start_cyc);
    end
    checks++; if (soc_cnt + rst_cnt + rd_cnt !== 0 || err_end !== 1'b0) begin
      failures++; $display("FAIL zero_quiet soc=%0d rst=%0d rd=%0d error=%0b exp 0,0,0,0", soc_cnt, rst_cnt, rd_cnt, err_end);
    end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 16; i++) jw[i] = $urandom;
    run_job(1, 10, 3, 1'b0, 1'b0, 1'b0, 8);
    checks++; if (aborted !== 1'b1 || sha_oe !== 1'b1) begin
      failures++; $display("FAIL midrst_reach aborted=%0b oe=%0b exp 1,1", aborted, sha_oe);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if ({msg_ready, sha_rst, sha_soc, sha_rd, sha_oe, hash_valid, busy, done, error} !== 9'b0 || sha_dout !== 32'h0) begin
      failures++; $display("FAIL midrst_async ctrl=%b dout=%h exp 0,0", {msg_ready, sha_rst, sha_soc, sha_rd, sha_oe, hash_valid, busy, done, error}, sha_dout);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_abc();
    run_job(1, 30, 4, 1'b1, 1'b0, 1'b0, 0);
    checks++; if (got_dig !== ABC || done_cnt !== 1) begin
      failures++; $display("FAIL midrst_abc got=%h done=%0d exp=%h,1", got_dig, done_cnt, ABC);
    end
  endtask

  task automatic test_restart_ignored();
    for (int i = 0; i < 32; i++) jw[i] = $urandom;
    run_job(2, 15, 6, 1'b0, 1'b0, 1'b1, 0);
    checks++; if (got_dig !== model_digest(2)) begin
      failures++; $display("FAIL restart_digest got=%h exp=%h", got_dig, model_digest(2));
    end
    checks++; if (done_cnt !== 1 || hv_cnt !== 8 || rst_cnt !== 1) begin
      failures++; $display("FAIL restart_once done=%0d beats=%0d rst=%0d exp 1,8,1", done_cnt, hv_cnt, rst_cnt);
    end
  endtask

  task automatic test_random_jobs();
    int nb;
    for (int j = 0; j < 5; j++) begin
      nb = $urandom_range(1, 3);
      for (int i = 0; i < 16 * nb; i++) jw[i] = $urandom;
      run_job(nb, $urandom_range(0, 50), $urandom_range(1, 20), 1'b1, 1'b0, 1'b0, 0);
      checks++; if (got_dig !== model_digest(nb)) begin
        failures++; $display("FAIL rand%0d_digest got=%h exp=%h", j, got_dig, model_digest(nb));
      end
      checks++; if (done_cnt !== 1 || soc_cnt !== nb || idx_bad + lag_bad + oe_bad + extra_xfer !== 0) begin
        failures++; $display("FAIL rand%0d_proto done=%0d soc=%0d exp_soc=%0d idx=%0d lag=%0d oe=%0d extra=%0d", j, done_cnt, soc_cnt, nb, idx_bad, lag_bad, oe_bad, extra_xfer);
      end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_two_block();
    test_timeout();
    test_zero_blocks();
    test_reset_mid_load();
    test_restart_ignored();
    test_random_jobs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
